// File: rtl/iq_interp_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// iq_interp_scheduler_pkg
// Shared definitions for the I/Q interpolation scheduler:
//   - sched_state_t : slot scheduler FSM states
//   - CH_I / CH_Q   : channel id carried on the filter output tuser
// ---------------------------------------------------------------------------
package iq_interp_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND_I = 3'd1,
        ST_SEND_Q = 3'd2,
        ST_ZERO_I = 3'd3,
        ST_ZERO_Q = 3'd4
    } sched_state_t;

    localparam logic CH_I = 1'b0;
    localparam logic CH_Q = 1'b1;

endpackage

// File: rtl/iq_interp_scheduler_fifo.sv
// ---------------------------------------------------------------------------
// iq_pair_fifo
// Small FIFO holding complete I/Q sample pairs, so a pair is never split.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (empties FIFO)
//   i_push, i_i, i_q  write strobe and pair data
//   i_pop             read strobe (head pair consumed on this edge)
//   o_i, o_q          head pair (valid while !o_empty)
//   o_full, o_empty   occupancy flags, derived from the registered count
// A push while full is taken only if a pop frees the slot on the same edge.
// ---------------------------------------------------------------------------
module iq_pair_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_i,
    input  logic [W-1:0] i_q,
    input  logic         i_pop,
    output logic [W-1:0] o_i,
    output logic [W-1:0] o_q,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] r_mem_i [DEPTH];
    logic [W-1:0] r_mem_q [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    assign o_i = r_mem_i[r_rd_ptr];
    assign o_q = r_mem_q[r_rd_ptr];

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_i[r_wr_ptr] <= i_i;
            r_mem_q[r_wr_ptr] <= i_q;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
        end
    end

endmodule

// File: rtl/iq_interp_scheduler.sv
// ---------------------------------------------------------------------------
// iq_interp_scheduler
// Shares one 2-channel interleaved smoothing filter between I and Q. Each
// input pair becomes 2*INTERP filter slots: I, Q, then INTERP-1 zero I/Q
// pairs. The interleaved filter output is re-paired into aligned I/Q.
// Ports:
//   clk_32M768, rst_n            clock, asynchronous active-low reset
//   in_i/q_tdata, in_tvalid/rdy  input pair stream (in_tready = !fifo full)
//   filt_s_tdata/tvalid/tready   slot stream into the filter (AXI-S)
//   filt_m_tdata/tvalid/tuser    filter output, tuser 0=I, 1=Q
//   out_i/q_tdata, out_tvalid    re-paired output, one-cycle strobe
//   stat_slip_cnt, stat_stall_cnt  only with INTERP_SCHED_STATS_EN defined:
//                                discarded-Q count and input stall cycles,
//                                both saturating
// Optional feature macro: INTERP_SCHED_STATS_EN
// ---------------------------------------------------------------------------
module iq_interp_scheduler
    import iq_interp_scheduler_pkg::*;
#(
    parameter int W          = 16,
    parameter int INTERP     = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk_32M768,
    input  logic         rst_n,
    input  logic [W-1:0] in_i_tdata,
    input  logic [W-1:0] in_q_tdata,
    input  logic         in_tvalid,
    output logic         in_tready,
    output logic [W-1:0] filt_s_tdata,
    output logic         filt_s_tvalid,
    input  logic         filt_s_tready,
    input  logic [W-1:0] filt_m_tdata,
    input  logic         filt_m_tvalid,
    input  logic         filt_m_tuser,
    output logic [W-1:0] out_i_tdata,
    output logic [W-1:0] out_q_tdata,
`ifdef INTERP_SCHED_STATS_EN
    output logic [15:0]  stat_slip_cnt,
    output logic [15:0]  stat_stall_cnt,
`endif
    output logic         out_tvalid
);

    localparam int ZW = (INTERP > 1) ? $clog2(INTERP) : 1;
    // Index of the final zero pair for one input pair.
    localparam logic [ZW-1:0] ZLAST = ZW'((INTERP > 1) ? INTERP - 2 : 0);

    // ---------------- input buffer ----------------
    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;
    logic [W-1:0] w_fifo_i;
    logic [W-1:0] w_fifo_q;

    assign in_tready = ~w_full;
    assign w_push    = in_tvalid & in_tready;

    iq_pair_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_32M768),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_i     (in_i_tdata),
        .i_q     (in_q_tdata),
        .i_pop   (w_pop),
        .o_i     (w_fifo_i),
        .o_q     (w_fifo_q),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ---------------- slot scheduler ----------------
    sched_state_t  r_state;
    sched_state_t  w_state_next;
    logic [W-1:0]  r_s_tdata;
    logic [W-1:0]  w_s_tdata_next;
    logic          r_s_tvalid;
    logic          w_s_tvalid_next;
    logic [W-1:0]  r_q_hold;        // Q of the pair currently being sent
    logic [W-1:0]  w_q_hold_next;
    logic [ZW-1:0] r_zcnt;
    logic [ZW-1:0] w_zcnt_next;
    logic          w_hs;
    logic          w_next_pair;     // current pair finished: start next or idle

    assign w_hs = r_s_tvalid & filt_s_tready;

    always_comb begin
        w_state_next    = r_state;
        w_s_tdata_next  = r_s_tdata;
        w_s_tvalid_next = r_s_tvalid;
        w_q_hold_next   = r_q_hold;
        w_zcnt_next     = r_zcnt;
        w_pop           = 1'b0;
        w_next_pair     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next_pair = 1'b1;
            end
            ST_SEND_I: begin
                if (w_hs) begin
                    w_state_next   = ST_SEND_Q;
                    w_s_tdata_next = r_q_hold;
                end
            end
            ST_SEND_Q: begin
                if (w_hs) begin
                    if (INTERP > 1) begin
                        w_state_next   = ST_ZERO_I;
                        w_s_tdata_next = '0;
                        w_zcnt_next    = '0;
                    end else begin
                        w_next_pair = 1'b1;
                    end
                end
            end
            ST_ZERO_I: begin
                if (w_hs) begin
                    w_state_next = ST_ZERO_Q;
                end
            end
            ST_ZERO_Q: begin
                if (w_hs) begin
                    if (r_zcnt == ZLAST) begin
                        w_next_pair = 1'b1;
                    end else begin
                        w_zcnt_next  = r_zcnt + 1'b1;
                        w_state_next = ST_ZERO_I;
                    end
                end
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_s_tvalid_next = 1'b0;
                w_s_tdata_next  = '0;
            end
        endcase

        // Popping straight into SEND_I keeps back-to-back pairs bubble-free.
        if (w_next_pair) begin
            if (!w_empty) begin
                w_pop           = 1'b1;
                w_state_next    = ST_SEND_I;
                w_s_tdata_next  = w_fifo_i;
                w_s_tvalid_next = 1'b1;
                w_q_hold_next   = w_fifo_q;
            end else begin
                w_state_next    = ST_IDLE;
                w_s_tdata_next  = '0;
                w_s_tvalid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_32M768 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_s_tdata  <= '0;
            r_s_tvalid <= 1'b0;
            r_q_hold   <= '0;
            r_zcnt     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_s_tdata  <= w_s_tdata_next;
            r_s_tvalid <= w_s_tvalid_next;
            r_q_hold   <= w_q_hold_next;
            r_zcnt     <= w_zcnt_next;
        end
    end

    assign filt_s_tdata  = r_s_tdata;
    assign filt_s_tvalid = r_s_tvalid;

    // ---------------- output re-pairing ----------------
    logic [W-1:0] r_i_latch;
    logic         r_have_i;
    logic [W-1:0] r_out_i;
    logic [W-1:0] r_out_q;
    logic         r_out_tvalid;

    // A newer I overwrites a stale one; a Q with no I pending is dropped.
    always_ff @(posedge clk_32M768 or negedge rst_n) begin
        if (!rst_n) begin
            r_i_latch    <= '0;
            r_have_i     <= 1'b0;
            r_out_i      <= '0;
            r_out_q      <= '0;
            r_out_tvalid <= 1'b0;
        end else begin
            r_out_tvalid <= 1'b0;
            if (filt_m_tvalid) begin
                if (filt_m_tuser == CH_I) begin
                    r_i_latch <= filt_m_tdata;
                    r_have_i  <= 1'b1;
                end else if (r_have_i) begin
                    r_out_i      <= r_i_latch;
                    r_out_q      <= filt_m_tdata;
                    r_out_tvalid <= 1'b1;
                    r_have_i     <= 1'b0;
                end
            end
        end
    end

    assign out_i_tdata = r_out_i;
    assign out_q_tdata = r_out_q;
    assign out_tvalid  = r_out_tvalid;

`ifdef INTERP_SCHED_STATS_EN
    // ---------------- statistics ----------------
    logic        w_slip;
    logic        w_stall;
    logic [15:0] r_slip_cnt;
    logic [15:0] r_stall_cnt;

    assign w_slip  = filt_m_tvalid & (filt_m_tuser == CH_Q) & ~r_have_i;
    assign w_stall = in_tvalid & ~in_tready;

    always_ff @(posedge clk_32M768 or negedge rst_n) begin
        if (!rst_n) begin
            r_slip_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_slip && (r_slip_cnt != 16'hFFFF))   r_slip_cnt  <= r_slip_cnt + 16'd1;
            if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stat_slip_cnt  = r_slip_cnt;
    assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_iq_interp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_iq_interp_scheduler
// Self-checking bench for iq_interp_scheduler (INTERP=2 main instance plus an
// INTERP=4 instance). Expected filter slots and output pairs are queued when
// stimulus is driven and compared as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_iq_interp_scheduler;

    localparam int W      = 16;
    localparam int INTERP = 2;

    typedef struct packed {
        logic [W-1:0] i;
        logic [W-1:0] q;
    } pair_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    // main DUT (INTERP=2)
    logic [W-1:0] in_i = '0, in_q = '0;
    logic         in_tvalid = 1'b0;
    logic         in_tready;
    logic [W-1:0] s_tdata;
    logic         s_tvalid;
    logic         s_tready = 1'b1;
    logic [W-1:0] m_tdata = '0;
    logic         m_tvalid = 1'b0;
    logic         m_tuser = 1'b0;
    logic [W-1:0] out_i, out_q;
    logic         out_tvalid;

    // second DUT (INTERP=4)
    logic [W-1:0] in4_i = '0, in4_q = '0;
    logic         in4_tvalid = 1'b0;
    logic         in4_tready;
    logic [W-1:0] s4_tdata;
    logic         s4_tvalid;
    logic         s4_tready = 1'b1;
    logic [W-1:0] m4_tdata = '0;
    logic         m4_tvalid = 1'b0;
    logic         m4_tuser = 1'b0;
    logic [W-1:0] out4_i, out4_q;
    logic         out4_tvalid;

`ifdef INTERP_SCHED_STATS_EN
    logic [15:0] slip_cnt, stall_cnt, slip4_cnt, stall4_cnt;
`endif

    always #5 clk = ~clk;

    iq_interp_scheduler #(.W(W), .INTERP(INTERP), .FIFO_DEPTH(2)) dut (
        .clk_32M768    (clk),
        .rst_n         (rst_n),
        .in_i_tdata    (in_i),
        .in_q_tdata    (in_q),
        .in_tvalid     (in_tvalid),
        .in_tready     (in_tready),
        .filt_s_tdata  (s_tdata),
        .filt_s_tvalid (s_tvalid),
        .filt_s_tready (s_tready),
        .filt_m_tdata  (m_tdata),
        .filt_m_tvalid (m_tvalid),
        .filt_m_tuser  (m_tuser),
        .out_i_tdata   (out_i),
        .out_q_tdata   (out_q),
`ifdef INTERP_SCHED_STATS_EN
        .stat_slip_cnt (slip_cnt),
        .stat_stall_cnt(stall_cnt),
`endif
        .out_tvalid    (out_tvalid)
    );

    iq_interp_scheduler #(.W(W), .INTERP(4), .FIFO_DEPTH(2)) dut4 (
        .clk_32M768    (clk),
        .rst_n         (rst_n),
        .in_i_tdata    (in4_i),
        .in_q_tdata    (in4_q),
        .in_tvalid     (in4_tvalid),
        .in_tready     (in4_tready),
        .filt_s_tdata  (s4_tdata),
        .filt_s_tvalid (s4_tvalid),
        .filt_s_tready (s4_tready),
        .filt_m_tdata  (m4_tdata),
        .filt_m_tvalid (m4_tvalid),
        .filt_m_tuser  (m4_tuser),
        .out_i_tdata   (out4_i),
        .out_q_tdata   (out4_q),
`ifdef INTERP_SCHED_STATS_EN
        .stat_slip_cnt (slip4_cnt),
        .stat_stall_cnt(stall4_cnt),
`endif
        .out_tvalid    (out4_tvalid)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int n_hs = 0;

    logic [W-1:0] slot_q[$];   // expected filter slots, main DUT
    int           hs_cyc[$];   // cycle index of each slot handshake
    pair_t        out_exp[$];  // expected output pairs, main DUT
    logic [W-1:0] mon_slot;
    pair_t        mon_pair;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: one line per transaction.
    always @(negedge clk) begin
        if (rst_n && s_tvalid && s_tready) begin
            n_hs++;
            hs_cyc.push_back(cyc);
            n_cmp++;
            if (slot_q.size() == 0) begin
                n_mis++;
                $display("FAIL slot_unexpected: got %h, required no slot", s_tdata);
            end else begin
                mon_slot = slot_q.pop_front();
                if (s_tdata !== mon_slot) begin
                    n_mis++;
                    $display("FAIL slot_data: got %h, required %h", s_tdata, mon_slot);
                end else begin
                    $display("slot   cyc=%0d data=%h", cyc, s_tdata);
                end
            end
        end
        if (rst_n && out_tvalid) begin
            n_cmp++;
            if (out_exp.size() == 0) begin
                n_mis++;
                $display("FAIL out_unexpected: got I=%h Q=%h, required no pulse", out_i, out_q);
            end else begin
                mon_pair = out_exp.pop_front();
                if (out_i !== mon_pair.i || out_q !== mon_pair.q) begin
                    n_mis++;
                    $display("FAIL out_pair: got I=%h Q=%h, required I=%h Q=%h",
                             out_i, out_q, mon_pair.i, mon_pair.q);
                end else begin
                    $display("out    cyc=%0d I=%h Q=%h", cyc, out_i, out_q);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_pair(input logic [W-1:0] i, input logic [W-1:0] q);
        logic hs;
        hs = 1'b0;
        in_i = i;
        in_q = q;
        in_tvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            hs = in_tready;
            tick();
            if (hs) break;
        end
        in_tvalid = 1'b0;
        if (!hs) begin
            n_cmp++;
            n_mis++;
            $display("FAIL push_timeout: got in_tready=0, required 1 within 50 cycles");
        end
        slot_q.push_back(i);
        slot_q.push_back(q);
        for (int z = 0; z < INTERP - 1; z++) begin
            slot_q.push_back('0);
            slot_q.push_back('0);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100 && slot_q.size() > 0; k++) tick();
        n_cmp++;
        if (slot_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain_timeout: got %0d slots pending, required 0", slot_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp += 6;
        if (in_tready !== 1'b1)  begin n_mis++; $display("FAIL rst_in_tready: got %b, required 1", in_tready); end
        if (s_tvalid !== 1'b0)   begin n_mis++; $display("FAIL rst_s_tvalid: got %b, required 0", s_tvalid); end
        if (s_tdata !== '0)      begin n_mis++; $display("FAIL rst_s_tdata: got %h, required 0", s_tdata); end
        if (out_tvalid !== 1'b0) begin n_mis++; $display("FAIL rst_out_tvalid: got %b, required 0", out_tvalid); end
        if (out_i !== '0)        begin n_mis++; $display("FAIL rst_out_i: got %h, required 0", out_i); end
        if (out_q !== '0)        begin n_mis++; $display("FAIL rst_out_q: got %h, required 0", out_q); end
    endtask

    task automatic test_single_pair();
        int h0;
        h0 = hs_cyc.size();
        push_pair(16'h1234, 16'h8001);
        wait_drain();
        tick();
        n_cmp += 2;
        if (hs_cyc.size() - h0 != 4 || hs_cyc[hs_cyc.size()-1] - hs_cyc[h0] != 3) begin
            n_mis++;
            $display("FAIL single_contig: got %0d slots, required 4 on consecutive cycles", hs_cyc.size() - h0);
        end
        if (s_tvalid !== 1'b0) begin
            n_mis++;
            $display("FAIL single_idle: got tvalid=%b, required 0", s_tvalid);
        end
    endtask

    task automatic test_back_to_back();
        int  h0;
        logic rdy_a, rdy_b;
        h0 = hs_cyc.size();
        push_pair(16'h0101, 16'h0202);
        rdy_a = in_tready;
        push_pair(16'h0303, 16'h0404);
        rdy_b = in_tready;
        wait_drain();
        n_cmp += 2;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
            n_mis++;
            $display("FAIL b2b_tready: got %b%b, required 11", rdy_a, rdy_b);
        end
        if (hs_cyc.size() - h0 != 8 || hs_cyc[hs_cyc.size()-1] - hs_cyc[h0] != 7) begin
            n_mis++;
            $display("FAIL b2b_contig: got %0d slots, required 8 with no bubble", hs_cyc.size() - h0);
        end
    endtask

    task automatic test_stall();
        push_pair(16'h1111, 16'h2222);
        tick();               // SEND_I visible, I handshake at next edge
        tick();               // now in SEND_Q
        s_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) push_pair(16'h3333, 16'h4444);
            else if (k == 1) push_pair(16'h5555, 16'h6666);
            else tick();
            n_cmp++;
            if (s_tdata !== 16'h2222 || s_tvalid !== 1'b1) begin
                n_mis++;
                $display("FAIL stall_hold: got tvalid=%b data=%h, required 1 2222", s_tvalid, s_tdata);
            end
            if (k == 1) begin
                n_cmp++;
                if (in_tready !== 1'b0) begin
                    n_mis++;
                    $display("FAIL stall_full: got in_tready=%b, required 0", in_tready);
                end
            end
        end
        s_tready = 1'b1;
        wait_drain();
    endtask

    task automatic test_repair();
        apply_reset();
        m_tvalid = 1'b1;
        m_tuser = 1'b1; m_tdata = 16'd7; tick();   // Q with no I: dropped
        m_tuser = 1'b0; m_tdata = 16'd5; tick();
        out_exp.push_back('{i: 16'd5, q: 16'd9});
        m_tuser = 1'b1; m_tdata = 16'd9; tick();
        m_tvalid = 1'b0;
        n_cmp++;
        if (out_tvalid !== 1'b1) begin
            n_mis++;
            $display("FAIL repair_latency: got out_tvalid=%b, required 1", out_tvalid);
        end
        tick();
        n_cmp++;
        if (out_tvalid !== 1'b0 || out_i !== 16'd5 || out_q !== 16'd9) begin
            n_mis++;
            $display("FAIL repair_hold: got v=%b I=%h Q=%h, required 0 0005 0009", out_tvalid, out_i, out_q);
        end
`ifdef INTERP_SCHED_STATS_EN
        n_cmp++;
        if (slip_cnt !== 16'd1) begin
            n_mis++;
            $display("FAIL repair_slip_cnt: got %0d, required 1", slip_cnt);
        end
`endif
        // Stale I overwritten by a newer I
        m_tvalid = 1'b1;
        m_tuser = 1'b0; m_tdata = 16'hAAAA; tick();
        m_tuser = 1'b0; m_tdata = 16'hBBBB; tick();
        out_exp.push_back('{i: 16'hBBBB, q: 16'hCCCC});
        m_tuser = 1'b1; m_tdata = 16'hCCCC; tick();
        m_tvalid = 1'b0;
        tick();
        n_cmp++;
        if (out_exp.size() != 0) begin
            n_mis++;
            $display("FAIL repair_count: got %0d pairs missing, required 0", out_exp.size());
        end
    endtask

    task automatic test_reset_midop();
        int hs0;
        m_tvalid = 1'b1; m_tuser = 1'b0; m_tdata = 16'h1111; tick();  // half-built pair
        m_tvalid = 1'b0;
        push_pair(16'h7777, 16'h8888);
        push_pair(16'h9999, 16'hAAAA);
        tick();
        tick();               // first pair now in ZERO_I, second buffered
        #2;
        slot_q.delete();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (s_tvalid !== 1'b0 || s_tdata !== '0 || out_tvalid !== 1'b0 || out_i !== '0 ||
            out_q !== '0 || in_tready !== 1'b1) begin
            n_mis++;
            $display("FAIL midop_async: got sv=%b sd=%h ov=%b oi=%h oq=%h rdy=%b, required 0 0 0 0 0 1",
                     s_tvalid, s_tdata, out_tvalid, out_i, out_q, in_tready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        hs0 = n_hs;
        m_tvalid = 1'b1; m_tuser = 1'b1; m_tdata = 16'h2222; tick();  // no I pending after reset
        m_tvalid = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        n_cmp++;
        if (n_hs != hs0) begin
            n_mis++;
            $display("FAIL midop_no_slots: got %0d slots after release, required 0", n_hs - hs0);
        end
    endtask

    task automatic test_interp4();
        logic [W-1:0] exp4[$];
        logic [W-1:0] got;
        int           n_got;
        int           c_first, c_last;
        n_got = 0;
        c_first = 0;
        c_last = 0;
        in4_i = 16'h0AAA; in4_q = 16'h0BBB; in4_tvalid = 1'b1;
        exp4.push_back(16'h0AAA);
        exp4.push_back(16'h0BBB);
        for (int z = 0; z < 6; z++) exp4.push_back('0);
        tick();
        in4_tvalid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (s4_tvalid && s4_tready) begin
                got = s4_tdata;
                if (n_got == 0) c_first = cyc;
                c_last = cyc;
                n_got++;
                n_cmp++;
                if (exp4.size() == 0) begin
                    n_mis++;
                    $display("FAIL i4_slot_extra: got %h, required no slot", got);
                end else if (got !== exp4[0]) begin
                    n_mis++;
                    $display("FAIL i4_slot: got %h, required %h", got, exp4[0]);
                    void'(exp4.pop_front());
                end else begin
                    $display("slot4  cyc=%0d data=%h", cyc, got);
                    void'(exp4.pop_front());
                end
            end
        end
        n_cmp++;
        if (n_got != 8 || c_last - c_first != 7) begin
            n_mis++;
            $display("FAIL i4_count: got %0d slots over %0d cycles, required 8 over 8", n_got, c_last - c_first + 1);
        end
        tick();
        m4_tvalid = 1'b1;
        m4_tuser = 1'b0; m4_tdata = 16'h0123; tick();
        m4_tuser = 1'b1; m4_tdata = 16'h0456; tick();
        m4_tvalid = 1'b0;
        n_cmp++;
        if (out4_tvalid !== 1'b1 || out4_i !== 16'h0123 || out4_q !== 16'h0456) begin
            n_mis++;
            $display("FAIL i4_out: got v=%b I=%h Q=%h, required 1 0123 0456", out4_tvalid, out4_i, out4_q);
        end else begin
            $display("out4   cyc=%0d I=%h Q=%h", cyc, out4_i, out4_q);
        end
        tick();
        n_cmp++;
        if (out4_tvalid !== 1'b0) begin
            n_mis++;
            $display("FAIL i4_pulse: got out_tvalid=%b, required 0", out4_tvalid);
        end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_back_to_back();
        test_stall();
        test_repair();
        test_reset_midop();
        test_interp4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
